// File: rtl/control_unit.sv
// control_unit: decoder plus run/step/halt sequencer driving the single-cycle cd datapath,
// with a retired-instruction counter.
module control_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             z,
   input  logic             run_en,
   input  logic             step_req,
   input  logic             resume,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       op_alu,
   output logic             pc_en,
   output logic             halted,
   output logic             step_ack,
   output logic [CNT_W-1:0] instr_count
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2;
   logic [1:0] state, state_nx;
   logic step_q, step_edge, ex, resuming, is_alu, is_ldi, is_halt, taken;
   assign step_edge = step_req & ~step_q;
   assign is_alu = ~opcode[5];
   assign is_ldi = opcode[5:2] == 4'b1000;
   assign is_halt = opcode == 6'b111111;
   assign taken = (opcode == 6'b110000) | ((opcode == 6'b110001) & z) | ((opcode == 6'b110010) & ~z);
   // reset gates the qualifier so enables drop the moment reset is asserted
   assign ex = ~reset & (state == RUN ? run_en : state == IDLE ? step_edge & ~run_en : 1'b0);
   assign resuming = ~reset & (state == HALT) & resume;
   assign state_nx = state == IDLE ? (run_en ? RUN : (ex & is_halt) ? HALT : IDLE) :
                     state == RUN  ? (~run_en ? IDLE : (ex & is_halt) ? HALT : RUN) :
                     state == HALT ? (resume ? IDLE : HALT) : IDLE;
   assign op_alu = opcode[4:2];
   assign s_inm = is_ldi;
   // leaving HALT steps the PC past the HALT instruction
   assign s_inc = resuming | ~taken;
   assign we3 = ex & (is_alu | is_ldi);
   assign wez = ex & is_alu;
   assign pc_en = (ex & ~is_halt) | resuming;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         step_q <= 1'b0;
         halted <= 1'b0;
         step_ack <= 1'b0;
         instr_count <= '0;
      end else begin
         state <= state_nx;
         step_q <= step_req;
         halted <= state_nx == HALT;
         step_ack <= (state == IDLE) & ex;
         instr_count <= instr_count + CNT_W'(ex & ~is_halt);
      end
   end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random and directed stimulus against a behavioural model of the
// sequencer, plus a small cd datapath model fed by the control word.
module tb_control_unit;
   logic clk = 1'b0, reset, z, run_en, step_req, resume;
   logic [5:0] opcode;
   logic s_inc, s_inm, we3, wez, pc_en, halted, step_ack;
   logic [2:0] op_alu;
   logic [15:0] instr_count;

   control_unit #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .z(z), .run_en(run_en),
      .step_req(step_req), .resume(resume), .s_inc(s_inc), .s_inm(s_inm),
      .we3(we3), .wez(wez), .op_alu(op_alu), .pc_en(pc_en), .halted(halted),
      .step_ack(step_ack), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
      end
   endtask

   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
   int mode, m_count;
   bit prev_step, m_ack, m_halted;
   bit e_ex, e_pc_en, e_we3, e_wez, e_sinc, e_sinm, e_hop;

   function automatic void model_reset();
      mode = M_IDLE; prev_step = 0; m_ack = 0; m_halted = 0; m_count = 0;
   endfunction

   function automatic void predict();
      bit se, taken, leaving;
      se = step_req && !prev_step;
      e_ex = 0;
      if (!reset)
         case (mode)
            M_RUN:  e_ex = run_en;
            M_IDLE: e_ex = se && !run_en;
            default: e_ex = 0;
         endcase
      e_hop = opcode == 6'h3F;
      taken = opcode == 6'h30 || (opcode == 6'h31 && z) || (opcode == 6'h32 && !z);
      e_sinm = opcode[5:2] == 4'b1000;
      e_we3 = e_ex && (!opcode[5] || e_sinm);
      e_wez = e_ex && !opcode[5];
      leaving = !reset && mode == M_HALT && resume;
      e_sinc = leaving || !taken;
      e_pc_en = (e_ex && !e_hop) || leaving;
   endfunction

   function automatic void advance();
      if (reset) begin
         model_reset();
         return;
      end
      m_ack = mode == M_IDLE && e_ex;
      if (e_ex && !e_hop) m_count = (m_count + 1) % 65536;
      case (mode)
         M_IDLE: mode = run_en ? M_RUN : (e_ex && e_hop) ? M_HALT : M_IDLE;
         M_RUN:  mode = !run_en ? M_IDLE : (e_ex && e_hop) ? M_HALT : M_RUN;
         default: mode = resume ? M_IDLE : M_HALT;
      endcase
      m_halted = mode == M_HALT;
      prev_step = step_req;
   endfunction

   logic [15:0] imem [1024];
   logic [7:0] rf [16];
   logic [9:0] pc;
   logic zf;
   bit use_prog = 0;
   bit d_we3, d_wez, d_pc_en, d_sinc, d_sinm;

   function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return a;
         3'd1: return ~a;
         3'd2: return a + b;
         3'd3: return a - b;
         3'd4: return a & b;
         3'd5: return a | b;
         3'd6: return -a;
         default: return -b;
      endcase
   endfunction

   function automatic void dp_update();
      logic [15:0] ins;
      logic [7:0] r;
      ins = imem[pc];
      r = alu(ins[14:12], rf[ins[11:8]], rf[ins[7:4]]);
      if (d_we3) rf[ins[3:0]] = d_sinm ? ins[11:4] : r;
      if (d_wez) zf = r == 8'd0;
      if (d_pc_en) pc = d_sinc ? pc + 10'd1 : ins[9:0];
   endfunction

   task automatic check_all();
      predict();
      check("s_inc", 32'(s_inc), 32'(e_sinc));
      check("s_inm", 32'(s_inm), 32'(e_sinm));
      check("we3", 32'(we3), 32'(e_we3));
      check("wez", 32'(wez), 32'(e_wez));
      check("op_alu", 32'(op_alu), 32'(opcode[4:2]));
      check("pc_en", 32'(pc_en), 32'(e_pc_en));
      check("halted", 32'(halted), 32'(m_halted));
      check("step_ack", 32'(step_ack), 32'(m_ack));
      check("instr_count", 32'(instr_count), 32'(m_count));
      d_we3 = we3; d_wez = wez; d_pc_en = pc_en; d_sinc = s_inc; d_sinm = s_inm;
   endtask

   task automatic tick();
      @(negedge clk);
      check_all();
      @(posedge clk);
      advance();
      if (use_prog) dp_update();
      #1;
      if (use_prog) begin
         opcode = imem[pc][15:10];
         z = zf;
      end
   endtask

   task automatic fetch();
      opcode = imem[pc][15:10];
      z = zf;
   endtask

   int acks, guard, r;
   logic [9:0] p0;
   logic [9:0] exp_pc [6] = '{10'h005, 10'h3F0, 10'h3F1, 10'h100, 10'h101, 10'h200};

   initial begin
      for (int i = 0; i < 1024; i++) imem[i] = 16'hCC00;
      imem[0] = 16'h8051; imem[1] = 16'h8032; imem[2] = 16'h2123; imem[3] = 16'hFC00;
      imem[4] = 16'hC7F0; imem[5] = 16'hCBF0; imem[10'h3F0] = 16'h3334; imem[10'h3F1] = 16'hC500;
      imem[10'h100] = 16'hCA00; imem[10'h101] = 16'hC200; imem[10'h200] = 16'hFC00;
      reset = 1; opcode = 6'h33; z = 0; run_en = 0; step_req = 0; resume = 0;
      pc = 0; zf = 0;
      model_reset();
      #1;
      check("rst_halted", 32'(halted), 0);
      check("rst_ack", 32'(step_ack), 0);
      check("rst_count", 32'(instr_count), 0);
      check("rst_pc_en", 32'(pc_en), 0);
      check("rst_we3", 32'(we3), 0);
      check("rst_s_inc", 32'(s_inc), 1);
      tick();
      reset = 0;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 11);
         opcode = r < 4 ? 6'($urandom) : r == 4 ? 6'h30 : r == 5 ? 6'h31 : r == 6 ? 6'h32 :
                  r == 7 ? 6'h3F : r == 8 ? {4'b1000, 2'($urandom)} : r == 9 ? 6'h33 : {1'b0, 5'($urandom)};
         z = 1'($urandom);
         if ($urandom_range(0, 7) == 0) run_en = ~run_en;
         step_req = $urandom_range(0, 2) == 0;
         resume = $urandom_range(0, 3) == 0;
         reset = 0;
         if ($urandom_range(0, 199) == 0) begin
            reset = 1;
            model_reset();
         end
         tick();
      end
      // program: LDI r1,5; LDI r2,3; ADD r3=r1+r2; HALT
      reset = 1; model_reset();
      run_en = 0; step_req = 0; resume = 0;
      pc = 0; zf = 0;
      for (int i = 0; i < 16; i++) rf[i] = 8'd0;
      use_prog = 1; fetch();
      tick();
      reset = 0; run_en = 1;
      for (int i = 0; i < 5; i++) tick();
      check("prog_halted", 32'(halted), 1);
      check("prog_r3", 32'(rf[3]), 8);
      check("prog_count", 32'(instr_count), 3);
      check("prog_pc", 32'(pc), 3);
      tick(); tick();
      check("halt_pc_hold", 32'(pc), 3);
      run_en = 0; resume = 1;
      tick();
      resume = 0;
      check("resume_pc", 32'(pc), 4);
      check("resume_halted", 32'(halted), 0);
      check("resume_count", 32'(instr_count), 3);
      check("resume_r3", 32'(rf[3]), 8);
      // jumps: JZ not taken, JNZ taken, SUB sets z, JZ taken, JNZ not taken, JMP
      run_en = 1;
      tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("jump_pc%0d", i), 32'(pc), 32'(exp_pc[i]));
      end
      tick();
      check("jump_halted", 32'(halted), 1);
      run_en = 0; resume = 1;
      tick();
      resume = 0;
      check("jump_resume_pc", 32'(pc), 32'h201);
      // single-step pulses
      p0 = pc; acks = 0;
      for (int k = 0; k < 3; k++) begin
         step_req = 1;
         tick();
         step_req = 0;
         check("step_ack_pulse", 32'(step_ack), 1);
         acks += int'(step_ack);
         for (int j = 0; j < 3; j++) begin
            tick();
            acks += int'(step_ack);
         end
      end
      check("step_acks", 32'(acks), 3);
      check("step_pc_adv", 32'(10'(pc - p0)), 3);
      p0 = pc; acks = 0; step_req = 1;
      for (int j = 0; j < 10; j++) begin
         tick();
         acks += int'(step_ack);
      end
      step_req = 0;
      tick();
      acks += int'(step_ack);
      check("hold_acks", 32'(acks), 1);
      check("hold_pc_adv", 32'(10'(pc - p0)), 1);
      // counter wrap with free-running NOPs
      use_prog = 0; opcode = 6'h33; z = 0; run_en = 1; guard = 0;
      while (m_count != 16'hFFFE && guard < 70000) begin
         tick();
         guard++;
      end
      check("wrap_fffe", 32'(instr_count), 32'hFFFE);
      tick();
      check("wrap_ffff", 32'(instr_count), 32'hFFFF);
      tick();
      check("wrap_0000", 32'(instr_count), 0);
      tick();
      check("wrap_0001", 32'(instr_count), 1);
      // asynchronous reset during an ALU op
      opcode = 6'h08;
      tick();
      #2;
      check("pre_rst_we3", 32'(we3), 1);
      reset = 1; model_reset();
      #1;
      check("arst_we3", 32'(we3), 0);
      check("arst_wez", 32'(wez), 0);
      check("arst_pc_en", 32'(pc_en), 0);
      check("arst_halted", 32'(halted), 0);
      check("arst_ack", 32'(step_ack), 0);
      check("arst_count", 32'(instr_count), 0);
      // step_req held across reset release
      run_en = 0; step_req = 1;
      tick();
      reset = 0;
      tick();
      check("rst_step_ack", 32'(step_ack), 1);
      check("rst_step_count", 32'(instr_count), 1);
      step_req = 0;
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
